// File: rtl/disp_cmd_pkg.sv
// disp_cmd_pkg: shared definitions for the sprite command dispatcher.
//   - Command word field positions (sub_comp, child, info, type, pp_sel, msg)
//   - Info codes that the dispatcher acts on (write, flush)
//   - Dispatcher FSM state encoding
//   - Helper that stamps the ping-pong select bit into a command word
package disp_cmd_pkg;

  localparam int SUB_MSB   = 31;
  localparam int SUB_LSB   = 26;
  localparam int CHILD_MSB = 25;
  localparam int CHILD_LSB = 21;
  localparam int INFO_MSB  = 20;
  localparam int INFO_LSB  = 17;
  localparam int TYPE_MSB  = 16;
  localparam int TYPE_LSB  = 14;
  localparam int PP_BIT    = 13;
  localparam int MSG_MSB   = 12;
  localparam int MSG_LSB   = 0;

  localparam logic [3:0] INFO_WRITE = 4'b0001;
  localparam logic [3:0] INFO_FLUSH = 4'b1111;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_VBL = 1'b1
  } state_e;

  // Replace the ping-pong select bit of a command word; software's value is ignored.
  function automatic logic [31:0] set_pp(input logic [31:0] word, input logic pp);
    logic [31:0] res;
    res         = word;
    res[PP_BIT] = pp;
    return res;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: single-clock synchronous FIFO with show-ahead head output.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      write request and data (ignored while full)
//   pop              remove head entry (ignored while empty)
//   rdata            current head entry, valid whenever empty=0
//   full, empty      status derived from the occupancy count
//   level            occupancy, 0..DEPTH
module cmd_fifo #(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6,
  parameter int W     = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [W-1:0]   wdata,
  input  logic           pop,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] level
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_q == (PTR_W+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next pointer and occupancy values; pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: buffers HPS command words and broadcasts one per clock to
// the sprite display blocks, owning ping-pong buffer selection. Flush
// (buffer-swap) commands are held until vertical blanking, at most one per
// blanking interval.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   chipselect, write,
//   writedata, waitrequest     Avalon-MM slave write port (waitrequest = FIFO full)
//   hcount, vcount             VGA raster position (vcount >= V_ACTIVE is blanking)
//   cmd_out                    registered broadcast command, 0 = no-op
//   front_buf                  buffer currently displayed
//   frame_irq                  one-cycle pulse per issued flush
//   frame_count                number of flushes issued (wraps)
//   fifo_level                 FIFO occupancy
module cmd_dispatcher
  import disp_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int PTR_W      = 6,
  parameter int V_ACTIVE   = 480
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           chipselect,
  input  logic           write,
  input  logic [31:0]    writedata,
  output logic           waitrequest,
  input  logic [9:0]     hcount,
  input  logic [9:0]     vcount,
  output logic [31:0]    cmd_out,
  output logic           front_buf,
  output logic           frame_irq,
  output logic [15:0]    frame_count,
  output logic [PTR_W:0] fifo_level
);

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        pop_s;
  logic        vblank_s;
  logic        flush_ok_s;
  logic        issue_s;
  logic [31:0] head_s;
  logic [3:0]  head_info_s;
  logic        unused_hcount_s;

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic        front_q, front_d;
  logic        irq_q, irq_d;
  logic [15:0] count_q, count_d;
  logic        flushed_q, flushed_d;

  assign unused_hcount_s = ^hcount;
  assign vblank_s        = (vcount >= 10'(V_ACTIVE));
  assign flush_ok_s      = vblank_s & ~flushed_q;
  assign push_s          = chipselect & write & ~fifo_full_s;
  assign head_info_s     = head_s[INFO_MSB:INFO_LSB];
  assign waitrequest     = fifo_full_s;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_s),
    .wdata (writedata),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Dispatch decision: what to pop, what to broadcast, and flush bookkeeping.
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    issue_s   = 1'b0;
    cmd_d     = 32'd0;
    front_d   = front_q;
    irq_d     = 1'b0;
    count_d   = count_q;
    flushed_d = flushed_q;

    case (state_q)
      RUN: begin
        if (!fifo_empty_s) begin
          case (head_info_s)
            INFO_WRITE: begin
              // Normal writes always target the back buffer.
              pop_s = 1'b1;
              cmd_d = set_pp(head_s, ~front_q);
            end
            INFO_FLUSH: begin
              if (flush_ok_s) begin
                issue_s = 1'b1;
              end else begin
                state_d = WAIT_VBL;
              end
            end
            default: begin
              // Unknown info codes are consumed without broadcasting.
              pop_s = 1'b1;
            end
          endcase
        end else begin
          cmd_d = 32'd0;
        end
      end
      WAIT_VBL: begin
        // The flush stays at the head, so later writes queue behind it.
        if (flush_ok_s) begin
          issue_s = 1'b1;
          state_d = RUN;
        end else begin
          state_d = WAIT_VBL;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (issue_s) begin
      pop_s     = 1'b1;
      cmd_d     = set_pp(head_s, ~front_q);
      front_d   = ~front_q;
      irq_d     = 1'b1;
      count_d   = count_q + 16'd1;
      flushed_d = 1'b1;
    end else begin
      // Re-arm only once the raster leaves blanking: one flush per interval.
      flushed_d = vblank_s ? flushed_q : 1'b0;
    end
  end

  // State and registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cmd_q     <= 32'd0;
      front_q   <= 1'b0;
      irq_q     <= 1'b0;
      count_q   <= 16'd0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      front_q   <= front_d;
      irq_q     <= irq_d;
      count_q   <= count_d;
      flushed_q <= flushed_d;
    end
  end

  assign cmd_out     = cmd_q;
  assign front_buf   = front_q;
  assign frame_irq   = irq_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Testbench for cmd_dispatcher: directed scenarios plus a randomized run,
// each compared against a queue-based behavioural model of the dispatcher.
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_buf;
  logic        frame_irq;
  logic [15:0] frame_count;
  logic [6:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queued words plus displayed buffer and flush bookkeeping.
  logic [31:0] q[$];
  logic        m_front;
  logic        m_flushed;
  logic        m_irq;
  logic [31:0] m_cmd;
  logic [15:0] m_count;

  cmd_dispatcher dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .hcount      (hcount),
    .vcount      (vcount),
    .cmd_out     (cmd_out),
    .front_buf   (front_buf),
    .frame_irq   (frame_irq),
    .frame_count (frame_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    q.delete();
    m_front   = 1'b0;
    m_flushed = 1'b0;
    m_irq     = 1'b0;
    m_cmd     = 32'd0;
    m_count   = 16'd0;
  endtask

  // One clock of the dispatcher rules, evaluated from pre-edge inputs.
  task automatic model_step();
    logic [31:0] h;
    bit vbl, accept, issued;
    vbl    = (vcount >= 10'd480);
    accept = chipselect && write && (q.size() < 64);
    m_cmd  = 32'd0;
    m_irq  = 1'b0;
    issued = 0;
    if (q.size() > 0) begin
      h = q[0];
      if (h[20:17] == 4'b0001) begin
        m_cmd = h; m_cmd[13] = ~m_front;
        void'(q.pop_front());
      end else if (h[20:17] == 4'b1111) begin
        if (vbl && !m_flushed) begin
          m_cmd = h; m_cmd[13] = ~m_front;
          m_front = ~m_front;
          m_irq = 1'b1;
          m_count = m_count + 16'd1;
          issued = 1;
          void'(q.pop_front());
        end
      end else begin
        void'(q.pop_front());
      end
    end
    if (issued) m_flushed = 1'b1;
    else if (!vbl) m_flushed = 1'b0;
    if (accept) q.push_back(writedata);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    hcount = 10'($urandom_range(0, 799));
  endtask

  function automatic logic [31:0] mk(input logic [3:0] info);
    logic [31:0] w;
    w = $urandom;
    w[20:17] = info;
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
    #2;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
    hcount = 10'd0; vcount = 10'd0;
    #3;
    model_clear();
    checks++; if (cmd_out !== 32'd0) begin errors++; $display("FAIL reset_cmd got %h exp 0", cmd_out); end
    checks++; if (front_buf !== 1'b0) begin errors++; $display("FAIL reset_front got %b exp 0", front_buf); end
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", frame_irq); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", frame_count); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", waitrequest); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    vcount = 10'd0;
    chipselect = 1'b1; write = 1'b1; writedata = 32'h08031001;
    tick();
    chipselect = 1'b0; write = 1'b0;
    checks++; if (cmd_out !== 32'd0 || fifo_level !== 7'd1) begin errors++; $display("FAIL single_queued cmd %h lvl %0d exp 0/1", cmd_out, fifo_level); end
    tick();
    checks++; if (cmd_out !== 32'h08033001) begin errors++; $display("FAIL single_issue got %h exp 08033001", cmd_out); end
    checks++; if (cmd_out !== m_cmd) begin errors++; $display("FAIL single_model got %h exp %h", cmd_out, m_cmd); end
    tick();
    checks++; if (cmd_out !== 32'd0 || fifo_level !== 7'd0) begin errors++; $display("FAIL single_after cmd %h lvl %0d exp 0/0", cmd_out, fifo_level); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    for (int i = 0; i < 3; i++) w[i] = mk(4'b0001);
    for (int i = 0; i < 5; i++) begin
      chipselect = (i < 3); write = (i < 3);
      writedata = (i < 3) ? w[i] : 32'd0;
      tick();
      checks++;
      if (fifo_level !== ((i < 3) ? 7'd1 : 7'd0)) begin errors++; $display("FAIL b2b_level[%0d] got %0d exp %0d", i, fifo_level, (i < 3) ? 1 : 0); end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (cmd_out !== (w[i-1] | 32'h00002000)) begin errors++; $display("FAIL b2b_cmd[%0d] got %h exp %h", i, cmd_out, w[i-1] | 32'h00002000); end
      end else begin
        checks++;
        if (cmd_out !== 32'd0) begin errors++; $display("FAIL b2b_idle[%0d] got %h exp 0", i, cmd_out); end
      end
    end
  endtask

  task automatic test_flush_wait();
    logic [31:0] f, w;
    f = mk(4'b1111); w = mk(4'b0001);
    vcount = 10'd100;
    chipselect = 1'b1; write = 1'b1;
    writedata = f; tick();
    writedata = w; tick();
    chipselect = 1'b0; write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vcount = (i == 5) ? 10'd479 : 10'(100 + i * 60);
      tick();
      checks++;
      if (cmd_out !== 32'd0 || fifo_level !== 7'd2 || frame_irq !== 1'b0) begin
        errors++; $display("FAIL flush_hold[%0d] cmd %h lvl %0d irq %b exp 0/2/0", i, cmd_out, fifo_level, frame_irq);
      end
    end
    vcount = 10'd480;
    tick();
    checks++; if (cmd_out !== (f | 32'h00002000)) begin errors++; $display("FAIL flush_issue got %h exp %h", cmd_out, f | 32'h00002000); end
    checks++; if (front_buf !== 1'b1 || frame_irq !== 1'b1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL flush_state front %b irq %b count %0d exp 1/1/1", front_buf, frame_irq, frame_count);
    end
    tick();
    checks++; if (cmd_out !== (w & 32'hFFFFDFFF)) begin errors++; $display("FAIL flush_next got %h exp %h", cmd_out, w & 32'hFFFFDFFF); end
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL flush_irq_pulse got %b exp 0", frame_irq); end
  endtask

  task automatic test_two_flushes();
    logic [31:0] f1, f2;
    f1 = mk(4'b1111); f2 = mk(4'b1111);
    do_reset();
    vcount = 10'd0; tick();
    vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1;
    writedata = f1; tick();
    writedata = f2; tick();
    chipselect = 1'b0; write = 1'b0;
    checks++; if (cmd_out !== (f1 | 32'h00002000) || frame_count !== 16'd1) begin
      errors++; $display("FAIL two_first cmd %h count %0d exp %h/1", cmd_out, frame_count, f1 | 32'h00002000);
    end
    for (int i = 0; i < 5; i++) begin
      vcount = 10'(480 + i * 8);
      tick();
      checks++;
      if (cmd_out !== 32'd0 || frame_count !== 16'd1 || fifo_level !== 7'd1) begin
        errors++; $display("FAIL two_hold[%0d] cmd %h count %0d lvl %0d exp 0/1/1", i, cmd_out, frame_count, fifo_level);
      end
    end
    vcount = 10'd0; tick();
    vcount = 10'd480; tick();
    checks++; if (cmd_out !== (f2 & 32'hFFFFDFFF) || frame_count !== 16'd2 || front_buf !== 1'b0) begin
      errors++; $display("FAIL two_second cmd %h count %0d front %b exp %h/2/0", cmd_out, frame_count, front_buf, f2 & 32'hFFFFDFFF);
    end
  endtask

  task automatic test_full();
    logic [31:0] words[65];
    logic [31:0] got[$];
    bit accepted;
    int n;
    words[0] = mk(4'b1111);
    for (int i = 1; i < 65; i++) words[i] = mk(4'b0001);
    vcount = 10'd0;
    chipselect = 1'b1; write = 1'b1;
    for (int i = 0; i < 64; i++) begin
      writedata = words[i];
      tick();
    end
    checks++; if (fifo_level !== 7'd64 || waitrequest !== 1'b1) begin
      errors++; $display("FAIL full_level lvl %0d wait %b exp 64/1", fifo_level, waitrequest);
    end
    writedata = words[64];
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fifo_level !== 7'd64 || waitrequest !== 1'b1 || cmd_out !== 32'd0) begin
        errors++; $display("FAIL full_hold[%0d] lvl %0d wait %b cmd %h exp 64/1/0", i, fifo_level, waitrequest, cmd_out);
      end
    end
    vcount = 10'd480;
    accepted = 0;
    n = 0;
    while (n < 200 && got.size() < 65) begin
      if (!accepted && q.size() < 64) accepted = 1;
      tick();
      if (accepted) begin chipselect = 1'b0; write = 1'b0; end
      if (cmd_out !== 32'd0) got.push_back(cmd_out);
      checks++;
      if (cmd_out !== m_cmd || fifo_level !== 7'(q.size())) begin
        errors++; $display("FAIL full_drain[%0d] cmd %h lvl %0d exp %h/%0d", n, cmd_out, fifo_level, m_cmd, q.size());
      end
      n++;
    end
    chipselect = 1'b0; write = 1'b0;
    checks++;
    if (got.size() != 65) begin
      errors++; $display("FAIL full_count got %0d words exp 65", got.size());
    end else begin
      for (int i = 0; i < 65; i++) begin
        if ((got[i] & 32'hFFFFDFFF) !== (words[i] & 32'hFFFFDFFF)) begin
          errors++; $display("FAIL full_order[%0d] got %h exp %h", i, got[i], words[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_random();
    int vc;
    int r;
    vc = 0;
    for (int n = 0; n < 400; n++) begin
      vc = (vc + $urandom_range(0, 40)) % 525;
      vcount = 10'(vc);
      chipselect = ($urandom_range(0, 3) != 0);
      write = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 5);
      writedata = (r < 3) ? mk(4'b0001) : (r < 5) ? mk(4'b1111) : $urandom;
      tick();
      checks++;
      if (cmd_out !== m_cmd || front_buf !== m_front || frame_irq !== m_irq ||
          frame_count !== m_count || fifo_level !== 7'(q.size()) || waitrequest !== (q.size() == 64)) begin
        errors++;
        $display("FAIL random[%0d] cmd %h/%h front %b/%b irq %b/%b count %0d/%0d lvl %0d/%0d wait %b (got/exp)",
                 n, cmd_out, m_cmd, front_buf, m_front, frame_irq, m_irq, frame_count, m_count,
                 fifo_level, q.size(), waitrequest);
      end
    end
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset_wait();
    do_reset();
    vcount = 10'd100;
    chipselect = 1'b1; write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      writedata = (i == 0) ? mk(4'b1111) : mk(4'b0001);
      tick();
    end
    chipselect = 1'b0; write = 1'b0;
    tick();
    checks++; if (fifo_level !== 7'd10) begin errors++; $display("FAIL rw_level got %0d exp 10", fifo_level); end
    reset = 1'b0;
    #2;
    model_clear();
    checks++; if (fifo_level !== 7'd0 || cmd_out !== 32'd0 || front_buf !== 1'b0 || frame_count !== 16'd0) begin
      errors++; $display("FAIL rw_async lvl %0d cmd %h front %b count %0d exp 0/0/0/0", fifo_level, cmd_out, front_buf, frame_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    vcount = 10'd480;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cmd_out !== 32'd0 || frame_count !== 16'd0 || frame_irq !== 1'b0 || front_buf !== 1'b0) begin
        errors++; $display("FAIL rw_after[%0d] cmd %h count %0d irq %b front %b exp all 0", i, cmd_out, frame_count, frame_irq, front_buf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_flush_wait();
    test_two_flushes();
    test_full();
    test_random();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
